microseq: RTL and testbench



---
 rtl/scamp_uinstr_pkg.sv | 60 ++++++
 rtl/microdecode.sv | 48 ++++
 rtl/microseq.sv | 81 ++++++++
 tb/tb_microseq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/scamp_uinstr_pkg.sv
// SCAMP microinstruction layout: field positions, bus codes, one-hot indices
// and the records shared by the sequencer and its decoder.
package scamp_uinstr_pkg;

    localparam int EO_BIT  = 15;
    localparam int ALU_HI  = 14;
    localparam int ALU_LO  = 8;
    localparam int BO_HI   = 14;
    localparam int BO_LO   = 12;
    localparam int RT_BIT  = 11;
    localparam int PP_BIT  = 10;
    localparam int BI_HI   = 7;
    localparam int BI_LO   = 5;
    localparam int JZ_BIT  = 4;
    localparam int JGT_BIT = 3;
    localparam int JLT_BIT = 2;
    localparam int JC_BIT  = 1;

    localparam logic [2:0] BO_PC  = 3'd0;
    localparam logic [2:0] BO_IRH = 3'd1;
    localparam logic [2:0] BO_IRL = 3'd2;
    localparam logic [2:0] BO_RAM = 3'd3;
    localparam logic [2:0] BO_DEV = 3'd6;

    localparam logic [2:0] BI_MAR = 3'd1;
    localparam logic [2:0] BI_IR  = 3'd2;
    localparam logic [2:0] BI_RAM = 3'd3;
    localparam logic [2:0] BI_X   = 3'd4;
    localparam logic [2:0] BI_Y   = 3'd5;
    localparam logic [2:0] BI_DEV = 3'd6;

    localparam int OH_PC  = 0;
    localparam int OH_IRH = 1;
    localparam int OH_IRL = 2;
    localparam int OH_MAR = 1;
    localparam int OH_IR  = 2;
    localparam int OH_RAM = 3;
    localparam int OH_X   = 4;
    localparam int OH_Y   = 5;
    localparam int OH_DEV = 6;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
    } flags_t;

    typedef struct packed {
        logic       eo;
        logic [6:0] alu_fn;
        logic [7:0] bus_out_oh;
        logic [7:0] bus_in_oh;
        logic       pp;
        logic       jz;
        logic       jgt;
        logic       jlt;
        logic       jc;
    } ctrl_t;

endpackage

// File: rtl/microdecode.sv
// Combinational decode of one 16-bit SCAMP microinstruction into an
// all-active-high control word plus the return-to-T0 bit.
module microdecode
    import scamp_uinstr_pkg::*;
(
    input  logic [15:0] uword,
    output ctrl_t       ctrl,
    output logic        rt
);

    // Bit 0 carries no meaning in either microinstruction format.
    logic unused_bit0;
    assign unused_bit0 = uword[0];

    always_comb begin
        ctrl    = '0;
        rt      = 1'b0;
        ctrl.eo = uword[EO_BIT];
        if (uword[EO_BIT]) begin
            ctrl.alu_fn = uword[ALU_HI:ALU_LO];
        end else begin
            rt      = uword[RT_BIT];
            ctrl.pp = uword[PP_BIT];
            case (uword[BO_HI:BO_LO])
                BO_PC:   ctrl.bus_out_oh[OH_PC]  = 1'b1;
                BO_IRH:  ctrl.bus_out_oh[OH_IRH] = 1'b1;
                BO_IRL:  ctrl.bus_out_oh[OH_IRL] = 1'b1;
                BO_RAM:  ctrl.bus_out_oh[OH_RAM] = 1'b1;
                BO_DEV:  ctrl.bus_out_oh[OH_DEV] = 1'b1;
                default: ;
            endcase
        end
        case (uword[BI_HI:BI_LO])
            BI_MAR:  ctrl.bus_in_oh[OH_MAR] = 1'b1;
            BI_IR:   ctrl.bus_in_oh[OH_IR]  = 1'b1;
            BI_RAM:  ctrl.bus_in_oh[OH_RAM] = 1'b1;
            BI_X:    ctrl.bus_in_oh[OH_X]   = 1'b1;
            BI_Y:    ctrl.bus_in_oh[OH_Y]   = 1'b1;
            BI_DEV:  ctrl.bus_in_oh[OH_DEV] = 1'b1;
            default: ;
        endcase
        ctrl.jz  = uword[JZ_BIT];
        ctrl.jgt = uword[JGT_BIT];
        ctrl.jlt = uword[JLT_BIT];
        ctrl.jc  = uword[JC_BIT];
    end

endmodule

// File: rtl/microseq.sv
// SCAMP microcode sequencer: T-state counter, ROM addressing, registered
// control word, ALU flag latch, conditional jumps and device-ready stall.
module microseq
    import scamp_uinstr_pkg::*;
#(
    parameter  int OPW    = 8,
    parameter  int TSTEPS = 8,
    parameter  int UW     = 16,
    localparam int TW     = $clog2(TSTEPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    opcode,
    output logic [OPW+TW-1:0] uaddr,
    input  logic [UW-1:0]     uinstr,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              dev_ready,
    output logic [TW-1:0]     tstate,
    output logic              eo,
    output logic [6:0]        alu_fn,
    output logic [7:0]        bus_out_oh,
    output logic [7:0]        bus_in_oh,
    output logic              pp,
    output logic              jmp_load,
    output logic              stall
);

    logic [TW-1:0] t_q;
    logic [TW-1:0] t_next;
    ctrl_t         ctrl_q;
    ctrl_t         ctrl_d;
    flags_t        flags_q;
    logic          rt;
    logic          stall_int;

    // Bits above the fixed 16-bit layout are reserved and never decoded.
    logic [UW-1:0] unused_uinstr;
    assign unused_uinstr = uinstr;

    microdecode u_microdecode (
        .uword (uinstr[15:0]),
        .ctrl  (ctrl_d),
        .rt    (rt)
    );

    assign uaddr     = {opcode, t_q};
    assign stall_int = (ctrl_q.bus_out_oh[OH_DEV] | ctrl_q.bus_in_oh[OH_DEV]) & ~dev_ready;
    assign t_next    = (rt || t_q == TW'(TSTEPS - 1)) ? '0 : t_q + 1'b1;

    // Flags are captured at the end of the EO step, so a jump registered at
    // the same edge evaluates against the freshly produced flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_q     <= '0;
            ctrl_q  <= '0;
            flags_q <= '0;
        end else if (!stall_int) begin
            t_q    <= t_next;
            ctrl_q <= ctrl_d;
            if (ctrl_q.eo) begin
                flags_q <= '{z: alu_z, n: alu_n, c: alu_c};
            end
        end
    end

    assign tstate     = t_q;
    assign eo         = ctrl_q.eo;
    assign alu_fn     = ctrl_q.alu_fn;
    assign bus_out_oh = ctrl_q.bus_out_oh;
    assign bus_in_oh  = ctrl_q.bus_in_oh;
    assign stall      = stall_int;
    // Only the PC increment is gated; other strobes repeat harmlessly.
    assign pp         = ctrl_q.pp & ~stall_int;
    assign jmp_load   = (ctrl_q.jz  & flags_q.z)
                      | (ctrl_q.jgt & ~flags_q.z & ~flags_q.n)
                      | (ctrl_q.jlt & flags_q.n)
                      | (ctrl_q.jc  & flags_q.c);

endmodule

// File: tb/tb_microseq.sv
// Self-checking bench for microseq: directed micro-programs plus a random
// phase, all compared against a behavioural sequencer model.
module tb_microseq;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  opcode;
    logic [10:0] uaddr;
    logic [15:0] uinstr;
    logic        alu_z, alu_n, alu_c;
    logic        dev_ready;
    logic [2:0]  tstate;
    logic        eo;
    logic [6:0]  alu_fn;
    logic [7:0]  bus_out_oh, bus_in_oh;
    logic        pp, jmp_load, stall;

    logic [10:0] uaddr5;
    logic [2:0]  tstate5;
    logic        eo5, pp5, jmp5, stall5;
    logic [6:0]  alu5;
    logic [7:0]  bo5, bi5;

    logic [15:0] rom [0:2047];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_t, m_t5;
    logic        m_eo, m_pp;
    logic [6:0]  m_alu;
    logic [7:0]  m_bo, m_bi;
    logic [3:0]  m_j;      // {JZ, JGT, JLT, JC}
    logic [2:0]  m_flags;  // {Z, N, C}

    always #5 clk = ~clk;

    assign uinstr = rom[uaddr];

    microseq dut (
        .clk(clk), .reset(reset), .opcode(opcode), .uaddr(uaddr), .uinstr(uinstr),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .dev_ready(dev_ready),
        .tstate(tstate), .eo(eo), .alu_fn(alu_fn), .bus_out_oh(bus_out_oh),
        .bus_in_oh(bus_in_oh), .pp(pp), .jmp_load(jmp_load), .stall(stall)
    );

    microseq #(.TSTEPS(5)) dut5 (
        .clk(clk), .reset(reset), .opcode(opcode), .uaddr(uaddr5), .uinstr(16'h0000),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .dev_ready(dev_ready),
        .tstate(tstate5), .eo(eo5), .alu_fn(alu5), .bus_out_oh(bo5),
        .bus_in_oh(bi5), .pp(pp5), .jmp_load(jmp5), .stall(stall5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk_bus(input int bo, input int bi, input int rt,
                                           input int pplus, input int j);
        return 16'((bo << 12) | (rt << 11) | (pplus << 10) | (bi << 5) | (j << 1));
    endfunction

    function automatic logic [15:0] mk_alu(input int fn, input int bi, input int j);
        return 16'(32'h8000 | (fn << 8) | (bi << 5) | (j << 1));
    endfunction

    function automatic logic [7:0] src_onehot(input int code);
        if (code == 0 || code == 1 || code == 2 || code == 3 || code == 6) return 8'(1 << code);
        return 8'h00;
    endfunction

    function automatic logic [7:0] dst_onehot(input int code);
        if (code >= 1 && code <= 6) return 8'(1 << code);
        return 8'h00;
    endfunction

    function automatic logic exp_stall();
        return (m_bo[6] || m_bi[6]) && !dev_ready;
    endfunction

    function automatic logic exp_jump();
        logic z, n, c;
        {z, n, c} = m_flags;
        return (m_j[3] && z) || (m_j[2] && !z && !n) || (m_j[1] && n) || (m_j[0] && c);
    endfunction

    task automatic model_clear();
        m_t = 0; m_t5 = 0; m_eo = 0; m_pp = 0; m_alu = '0;
        m_bo = '0; m_bi = '0; m_j = '0; m_flags = '0;
    endtask

    task automatic model_edge();
        logic [15:0] u;
        logic        rt;
        if (!exp_stall()) begin
            if (m_eo) m_flags = {alu_z, alu_n, alu_c};
            u     = rom[{opcode, 3'(m_t)}];
            m_eo  = u[15];
            rt    = !m_eo && u[11];
            m_pp  = !m_eo && u[10];
            m_alu = m_eo ? u[14:8] : 7'h00;
            m_bo  = m_eo ? 8'h00 : src_onehot(int'(u[14:12]));
            m_bi  = dst_onehot(int'(u[7:5]));
            m_j   = u[4:1];
            m_t   = (rt || m_t == 7) ? 0 : m_t + 1;
        end
        m_t5 = (m_t5 == 4) ? 0 : m_t5 + 1;
    endtask

    // Called just after a rising edge: drive inputs, check the combinational
    // outputs for this cycle, clock once and check the registered outputs.
    task automatic step(input logic [7:0] op, input bit rdy, input logic [2:0] flg);
        opcode = op;
        dev_ready = rdy;
        {alu_z, alu_n, alu_c} = flg;
        #1;
        check("uaddr",    32'(uaddr),    32'({op, 3'(m_t)}));
        check("uaddr5",   32'(uaddr5),   32'({op, 3'(m_t5)}));
        check("stall",    32'(stall),    32'(exp_stall()));
        check("pp",       32'(pp),       32'(m_pp && !exp_stall()));
        check("jmp_load", 32'(jmp_load), 32'(exp_jump()));
        model_edge();
        @(posedge clk);
        #1;
        check("tstate",     32'(tstate),     32'(m_t));
        check("tstate5",    32'(tstate5),    32'(m_t5));
        check("eo",         32'(eo),         32'(m_eo));
        check("alu_fn",     32'(alu_fn),     32'(m_alu));
        check("bus_out_oh", 32'(bus_out_oh), 32'(m_bo));
        check("bus_in_oh",  32'(bus_in_oh),  32'(m_bi));
    endtask

    // Asserts reset between edges and checks that outputs clear immediately.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_tstate",   32'(tstate),     32'd0);
        check("rst_tstate5",  32'(tstate5),    32'd0);
        check("rst_eo",       32'(eo),         32'd0);
        check("rst_alu_fn",   32'(alu_fn),     32'd0);
        check("rst_bus_out",  32'(bus_out_oh), 32'd0);
        check("rst_bus_in",   32'(bus_in_oh),  32'd0);
        check("rst_pp",       32'(pp),         32'd0);
        check("rst_jmp_load", 32'(jmp_load),   32'd0);
        check("rst_stall",    32'(stall),      32'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        opcode = '0;
        dev_ready = 1'b1;
        {alu_z, alu_n, alu_c} = 3'b000;
        for (int i = 0; i < 2048; i++) rom[i] = 16'($urandom);

        // Straight-line program: PC -> MAR every step, wraps after T7
        for (int t = 0; t < 8; t++) rom[{8'h12, 3'(t)}] = mk_bus(0, 1, 0, 0, 0);
        // Early return at T2
        rom[{8'h22, 3'd0}] = mk_bus(1, 2, 0, 0, 0);
        rom[{8'h22, 3'd1}] = mk_bus(2, 4, 0, 0, 0);
        rom[{8'h22, 3'd2}] = mk_bus(3, 5, 1, 0, 0);
        for (int t = 3; t < 8; t++) rom[{8'h22, 3'(t)}] = mk_bus(0, 1, 0, 0, 0);
        // EO then JZ; EO then JGT
        rom[{8'h30, 3'd0}] = mk_alu(7'h2A, 4, 0);
        rom[{8'h30, 3'd1}] = mk_bus(1, 0, 0, 0, 8);
        rom[{8'h30, 3'd2}] = mk_alu(7'h15, 5, 0);
        rom[{8'h30, 3'd3}] = mk_bus(2, 0, 1, 0, 4);
        // DO with P+ on a slow device
        rom[{8'h40, 3'd0}] = mk_bus(6, 0, 0, 1, 0);
        rom[{8'h40, 3'd1}] = mk_bus(0, 3, 1, 0, 0);
        // DI combined with EO, followed by flag-dependent jumps
        rom[{8'h50, 3'd0}] = mk_alu(7'h11, 6, 0);
        rom[{8'h50, 3'd1}] = mk_bus(1, 0, 0, 0, 1);
        rom[{8'h50, 3'd2}] = mk_bus(2, 0, 1, 0, 8);
        // Unused bus codes decode to nothing
        rom[{8'h60, 3'd0}] = mk_bus(4, 0, 0, 0, 0);
        rom[{8'h60, 3'd1}] = mk_bus(5, 7, 0, 0, 0);
        rom[{8'h60, 3'd2}] = mk_bus(7, 0, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int k = 0; k < 10; k++) step(8'h12, 1'b1, 3'b000);

        for (int k = 0; k < 5; k++) step(8'h22, 1'b1, 3'b000);
        do_reset();

        for (int k = 0; k < 4; k++) step(8'h30, 1'b1, 3'b100);
        do_reset();
        for (int k = 0; k < 4; k++) step(8'h30, 1'b1, 3'b010);
        do_reset();

        step(8'h40, 1'b1, 3'b000);
        for (int k = 0; k < 3; k++) step(8'h40, 1'b0, 3'b000);
        for (int k = 0; k < 3; k++) step(8'h40, 1'b1, 3'b000);
        do_reset();

        step(8'h50, 1'b1, 3'b000);
        step(8'h50, 1'b0, 3'b001);
        step(8'h50, 1'b0, 3'b100);
        step(8'h50, 1'b0, 3'b111);
        step(8'h50, 1'b1, 3'b101);
        for (int k = 0; k < 3; k++) step(8'h50, 1'b1, 3'b000);
        do_reset();

        for (int k = 0; k < 4; k++) step(8'h60, 1'b1, 3'b000);
        do_reset();

        for (int k = 0; k < 600; k++) begin
            step(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
